if_fetch_unit: RTL

Instruction-fetch stage of the 5-stage RISC-V pipeline. It sits directly upstream of the IF/ID interstage register. It owns the program counter, issues single-outstanding requests to instruction memory over a valid/ready request and valid response channel, and buffers the returned word until ID accepts it. It applies branch redirects from EX and generates `IF_Flush` for the IF/ID register.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/if_fetch_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               State encoding, the bubble instruction, the default reset PC
//               and the instruction width.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned         INSTR_W          = 32;
    localparam logic [INSTR_W-1:0]  NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0]         DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues one outstanding
//               request at a time to instruction memory, buffers the returned
//               word until ID accepts it, applies EX branch redirects and
//               raises IF_Flush for the IF/ID register.
// Ports       : clk, reset_n         - clock, async active-low reset
//               IF_ID_RegWrite       - 1 = ID accepts this cycle, 0 = stall
//               branch_taken/_target - redirect from EX
//               imem_req_*           - valid/ready fetch request channel
//               imem_resp_*          - response channel (one per request)
//               pc, instruction      - presented to IF/ID
//               IF_Flush             - squash IF/ID this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        IF_ID_RegWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        IF_Flush
);
    import fetch_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ibuf_q, ibuf_d;
    logic         drop_q, drop_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ibuf_q  <= NOP_INSTR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ibuf_d         = ibuf_q;
        drop_d         = drop_q;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_q;
        pc             = pc_q;
        instruction    = NOP_INSTR;
        IF_Flush       = branch_taken;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // The redirect cycle never issues a request: the address
                // would be stale by the next edge.
                imem_req_valid = !branch_taken;
                if (!branch_taken && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q || branch_taken) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        ibuf_d  = imem_resp_data;
                        state_d = S_HOLD;
                    end
                end else if (branch_taken) begin
                    // Response still in flight: remember to discard it.
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                instruction = ibuf_q;
                if (branch_taken) begin
                    state_d = S_REQ;
                end else if (IF_ID_RegWrite) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect overrides any sequential PC update.
        if (branch_taken) begin
            pc_d = {branch_target[31:2], 2'b00};
        end
    end

endmodule : if_fetch_unit
`default_nettype wire
